// File: rtl/gcd_pkg.sv
// Shared types and helpers for the streaming GCD block.
package gcd_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} gcd_state_e;

   // The level counter needs one extra bit so that "full" (== depth) fits.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/gcd_core.sv
// Iterative subtract GCD engine: takes one operand pair from the FIFO head,
// steps once per cycle, and holds the result until the consumer accepts it.
module gcd_core
   import gcd_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             i_head_vld,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_pop,
   input  logic             i_res_ready,
   output logic             o_res_valid,
   output logic [WIDTH-1:0] o_result,
   output logic             o_busy
);

   gcd_state_e       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_ra, r_rb, r_res;
   logic [WIDTH-1:0] w_ra_nxt, w_rb_nxt, w_res_nxt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_ra    <= '0;
         r_rb    <= '0;
         r_res   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ra    <= w_ra_nxt;
         r_rb    <= w_rb_nxt;
         r_res   <= w_res_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ra_nxt    = r_ra;
      w_rb_nxt    = r_rb;
      w_res_nxt   = r_res;
      o_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_head_vld) begin
               o_pop    = 1'b1;
               w_ra_nxt = i_a;
               w_rb_nxt = i_b;
               // A zero operand short-circuits: GCD(x,0)=x, GCD(0,0)=0.
               if (i_a == '0 || i_b == '0) begin
                  w_res_nxt   = i_a | i_b;
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = CALC;
               end
            end
         end
         CALC: begin
            if (r_ra == r_rb) begin
               w_res_nxt   = r_ra;
               w_state_nxt = DONE;
            end else if (r_ra > r_rb) begin
               w_ra_nxt = r_ra - r_rb;
            end else begin
               w_rb_nxt = r_rb - r_ra;
            end
         end
         DONE: begin
            if (i_res_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_res_valid = (r_state == DONE);
   assign o_busy      = (r_state != IDLE);
   assign o_result    = r_res;

endmodule

// File: rtl/gcd_stream.sv
// Handshaked GCD block: operand-pair FIFO (first-word-fall-through) feeding gcd_core.
// Optional completed-result counter on res_count_o when GCD_STATS_EN is defined.
module gcd_stream
   import gcd_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [WIDTH-1:0]           a_i,
   input  logic [WIDTH-1:0]           b_i,
   output logic                       res_valid_o,
   input  logic                       res_ready_i,
   output logic [WIDTH-1:0]           result_o,
   output logic                       busy_o,
   output logic [lvl_w(DEPTH)-1:0]    fifo_level_o
`ifdef GCD_STATS_EN
   ,
   output logic [CNT_W-1:0]           res_count_o
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = lvl_w(DEPTH);

   logic [WIDTH-1:0] r_mem_a [DEPTH];
   logic [WIDTH-1:0] r_mem_b [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_push, w_pop, w_head_vld;

   assign in_ready_o   = (r_level != LW'(DEPTH));
   assign w_push       = in_valid_i && in_ready_o;
   assign w_head_vld   = (r_level != '0);
   assign fifo_level_o = r_level;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr] <= a_i;
         r_mem_b[r_wr_ptr] <= b_i;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   gcd_core #(.WIDTH(WIDTH)) u_core (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .i_head_vld  (w_head_vld),
      .i_a         (r_mem_a[r_rd_ptr]),
      .i_b         (r_mem_b[r_rd_ptr]),
      .o_pop       (w_pop),
      .i_res_ready (res_ready_i),
      .o_res_valid (res_valid_o),
      .o_result    (result_o),
      .o_busy      (busy_o)
   );

`ifdef GCD_STATS_EN
   logic [CNT_W-1:0] r_res_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                         r_res_cnt <= '0;
      else if (res_valid_o && res_ready_i) r_res_cnt <= r_res_cnt + CNT_W'(1);
   end

   assign res_count_o = r_res_cnt;
`endif

endmodule

// File: tb/tb_gcd_stream.sv
// Directed self-checking bench for gcd_stream (WIDTH=4, DEPTH=4); counter checks when GCD_STATS_EN.
module tb_gcd_stream;

   localparam int W  = 4;
   localparam int D  = 4;
   localparam int CW = 16;
   localparam int LW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0, b = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [W-1:0]  result;
   logic          busy;
   logic [LW-1:0] level;
`ifdef GCD_STATS_EN
   logic [CW-1:0] res_count;
`endif

   gcd_stream #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .a_i          (a),
      .b_i          (b),
      .res_valid_o  (res_valid),
      .res_ready_i  (res_ready),
      .result_o     (result),
      .busy_o       (busy),
      .fifo_level_o (level)
`ifdef GCD_STATS_EN
      ,
      .res_count_o  (res_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [W-1:0] av;
      logic [W-1:0] bv;
      logic [W-1:0] exp;
      int           lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] av, input logic [W-1:0] bv);
      int n = 0;
      while (!in_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("push_timeout", 32'd0, 32'd1);
      a = av;
      b = bv;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Returns the cycle index (pop cycle = 0) at which res_valid_o is first seen.
   task automatic wait_valid(output int k);
      k = 0;
      while (!res_valid && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (!res_valid) chk("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_vec(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp, input int lat);
      int k;
      push(av, bv);
      chk({nm, " level_at_pop"}, 32'(level), 32'd1);
      chk({nm, " busy_at_pop"}, 32'(busy), 32'd0);
      wait_valid(k);
      chk({nm, " latency"}, k, lat);
      chk({nm, " result"}, 32'(result), 32'(exp));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({nm, " valid_after_hs"}, 32'(res_valid), 32'd0);
      chk({nm, " busy_after_hs"}, 32'(busy), 32'd0);
   endtask

   vec_t vecs[11];
   logic [W-1:0] fill_exp[5];
   logic [W-1:0] strm_a[4], strm_b[4], strm_exp[4];

   initial begin
      int k, extra, max_lvl;

      vecs[0]  = '{4'd15, 4'd1,  4'd1,  16};
      vecs[1]  = '{4'd9,  4'd9,  4'd9,  2};
      vecs[2]  = '{4'd0,  4'd6,  4'd6,  1};
      vecs[3]  = '{4'd0,  4'd0,  4'd0,  1};
      vecs[4]  = '{4'd6,  4'd0,  4'd6,  1};
      vecs[5]  = '{4'd8,  4'd12, 4'd4,  4};
      vecs[6]  = '{4'd7,  4'd3,  4'd1,  6};
      vecs[7]  = '{4'd10, 4'd4,  4'd2,  5};
      vecs[8]  = '{4'd6,  4'd9,  4'd3,  4};
      vecs[9]  = '{4'd5,  4'd3,  4'd1,  5};
      vecs[10] = '{4'd1,  4'd15, 4'd1,  16};
      fill_exp = '{4'd4, 4'd1, 4'd2, 4'd3, 4'd1};
      strm_a   = '{4'd8, 4'd7, 4'd10, 4'd6};
      strm_b   = '{4'd12, 4'd3, 4'd4, 4'd9};
      strm_exp = '{4'd4, 4'd1, 4'd2, 4'd3};

      // Reset state
      #12;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst res_valid", 32'(res_valid), 32'd0);
      chk("rst result", 32'(result), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst level", 32'(level), 32'd0);
`ifdef GCD_STATS_EN
      chk("rst count", 32'(res_count), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // (12,8) with a 3-cycle consumer stall
      push(4'd12, 4'd8);
      chk("hold level_at_pop", 32'(level), 32'd1);
      wait_valid(k);
      chk("hold latency", k, 4);
      repeat (3) begin
         @(negedge clk);
         chk("hold result", 32'(result), 32'd4);
         chk("hold valid", 32'(res_valid), 32'd1);
         chk("hold busy", 32'(busy), 32'd1);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("hold released", 32'(busy), 32'd0);
      chk("hold result_kept", 32'(result), 32'd4);

      foreach (vecs[i])
         run_vec($sformatf("vec%0d", i), vecs[i].av, vecs[i].bv, vecs[i].exp, vecs[i].lat);

      // Fill: engine holds the first pair, FIFO takes the next four
      for (int i = 0; i < 4; i++) push(strm_a[i], strm_b[i]);
      push(4'd5, 4'd3);
      chk("fill level", 32'(level), 32'd4);
      chk("fill in_ready", 32'(in_ready), 32'd0);
      a = 4'd1; b = 4'd1; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("fill 6th_level", 32'(level), 32'd4);
         chk("fill 6th_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_valid(k);
         chk($sformatf("fill res%0d", i), 32'(result), 32'(fill_exp[i]));
         @(negedge clk);
      end
      extra = 0;
      repeat (25) begin
         @(negedge clk);
         if (res_valid) extra++;
      end
      chk("fill no_extra", extra, 0);
      chk("fill drained", 32'(level), 32'd0);

      // Streaming, three passes to wrap the pointers
      max_lvl = 0;
      fork
         begin
            for (int p = 0; p < 3; p++)
               for (int i = 0; i < 4; i++) push(strm_a[i], strm_b[i]);
         end
         begin
            for (int n = 0; n < 12; n++) begin
               int kk = 0;
               while (!res_valid && kk < 60) begin
                  if (int'(level) > max_lvl) max_lvl = int'(level);
                  @(negedge clk);
                  kk++;
               end
               chk($sformatf("strm res%0d", n), 32'(result), 32'(strm_exp[n % 4]));
               @(negedge clk);
            end
         end
      join
      chk("strm max_level", 32'(max_lvl <= D), 32'd1);
      res_ready = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of (15,1)
      push(4'd15, 4'd1);
      push(4'd6, 4'd9);
      repeat (4) @(negedge clk);
      chk("arst pre_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst in_ready", 32'(in_ready), 32'd1);
      chk("arst res_valid", 32'(res_valid), 32'd0);
      chk("arst result", 32'(result), 32'd0);
      chk("arst busy", 32'(busy), 32'd0);
      chk("arst level", 32'(level), 32'd0);
`ifdef GCD_STATS_EN
      chk("arst count", 32'(res_count), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec("post_rst", 4'd6, 4'd4, 4'd2, 4);

      // Stall after reset: counter must not move while ready is low
      push(4'd5, 4'd3);
      wait_valid(k);
      repeat (3) begin
         @(negedge clk);
         chk("stall valid", 32'(res_valid), 32'd1);
`ifdef GCD_STATS_EN
         chk("stall count", 32'(res_count), 32'd1);
`endif
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      run_vec("cnt3", 4'd9, 4'd9, 4'd9, 2);
      run_vec("cnt4", 4'd0, 4'd6, 4'd6, 1);
      run_vec("cnt5", 4'd8, 4'd12, 4'd4, 4);
`ifdef GCD_STATS_EN
      chk("count5", 32'(res_count), 32'(5 % (1 << CW)));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
